// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode 7-segment display.
// The bench-facing view of the display is a nibble word. It is captured on
// `load` and committed only at a frame boundary, so one frame never shows a mix
// of old and new digits. Each digit slot starts with a forced blank interval to
// suppress ghosting. Hex glyphs and leading-zero suppression are optional.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   load        one-cycle strobe capturing value/hex_en/lz_en
//   value       packed nibbles, digit i = value[4i+3:4i], digit 0 least significant
//   hex_en      1: codes 10..15 show A,b,C,d,E,F; 0: those codes blank
//   lz_en       1: leading zero digits blank (digit 0 never blanks)
//   seg         active-low segments {g,f,e,d,c,b,a}
//   an          active-low digit enables, at most one low
//   frame_start one-cycle pulse on the first cycle of each frame
//   pending     a captured value is waiting for the next frame boundary
module seg7_scan_driver #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  hex_en,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0] DIG_MAX   = DIG_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'h7F;

  // Display word plus its rendering modes, kept together so they commit atomically.
  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic             hex_en;
    logic             lz_en;
  } disp_cfg_t;

  // Slot phase, derived purely from the slot counter.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  // Registered state
  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIG_W-1:0] dig_q;
  disp_cfg_t        shadow_q;
  disp_cfg_t        disp_q;
  logic             pending_q;
  logic [6:0]       seg_q;
  logic [DIGITS-1:0] an_q;
  logic             fs_q;

  // Next-state values
  logic             run_d;
  logic [CNT_W-1:0] cnt_d;
  logic [DIG_W-1:0] dig_d;
  disp_cfg_t        shadow_d;
  disp_cfg_t        disp_d;
  logic             pending_d;
  logic [6:0]       seg_d;
  logic [DIGITS-1:0] an_d;
  logic             fs_d;

  // Combinational helpers
  disp_cfg_t        load_cfg;
  logic             boundary;
  phase_t           phase;
  logic [VAL_W-1:0] upper;
  logic [3:0]       nibble;
  logic             lz_blank;

  // Active-low glyph for one nibble; undefined hex codes blank unless enabled.
  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
    logic [6:0] g;
    g = SEG_OFF;
    case (code)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = hex ? 7'b0001000 : SEG_OFF;
      4'hB: g = hex ? 7'b0000011 : SEG_OFF;
      4'hC: g = hex ? 7'b1000110 : SEG_OFF;
      4'hD: g = hex ? 7'b0100001 : SEG_OFF;
      4'hE: g = hex ? 7'b0000110 : SEG_OFF;
      4'hF: g = hex ? 7'b0001110 : SEG_OFF;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      dig_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= '1;
      fs_q      <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fs_q      <= fs_d;
    end
  end

  // Scan sequencing, load/commit handling and output decode.
  // Outputs are decoded from the next-state values so that the registered
  // outputs always match the registered cnt/dig with no added latency.
  always_comb begin
    run_d     = 1'b1;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    seg_d     = SEG_OFF;
    an_d      = '1;
    fs_d      = 1'b0;
    upper     = '0;
    nibble    = '0;
    lz_blank  = 1'b0;
    phase     = PH_BLANK;

    load_cfg.value  = value;
    load_cfg.hex_en = hex_en;
    load_cfg.lz_en  = lz_en;

    // The first edge after reset release opens frame 0 at cnt=0/dig=0.
    if (!run_q) begin
      cnt_d    = '0;
      dig_d    = '0;
      boundary = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (dig_q == DIG_MAX) begin
        dig_d    = '0;
        boundary = 1'b1;
      end else begin
        dig_d = dig_q + DIG_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load) begin
      shadow_d  = load_cfg;
      pending_d = 1'b1;
    end

    // A load coinciding with the boundary bypasses straight into the display.
    if (boundary) begin
      if (load) begin
        disp_d    = load_cfg;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end

    phase = (cnt_d < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    fs_d  = (cnt_d == '0) && (dig_d == '0);

    // Nibbles from the current digit upward; all-zero means a leading zero.
    upper  = disp_d.value >> {dig_d, 2'b00};
    nibble = upper[3:0];
    if (disp_d.lz_en && (dig_d != '0)) begin
      lz_blank = (upper == '0);
    end

    case (phase)
      PH_DRIVE: begin
        an_d = ~(DIGITS'(1) << dig_d);
        if (!lz_blank) begin
          seg_d = glyph(nibble, disp_d.hex_en);
        end
      end
      default: begin
        an_d  = '1;
        seg_d = SEG_OFF;
      end
    endcase
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=3, SCAN_DIV=8, BLANK_CYC=2.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS    = 3;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = DIGITS * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [11:0] value;
  logic        hex_en;
  logic        lz_en;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_start;
  logic        pending;

  int tests;
  int fails;

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .hex_en     (hex_en),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_start(frame_start),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one full frame starting at its first cycle, checking every cycle
  // against hand-computed glyphs g0..g2. Optional loads are issued at
  // frame cycles la/la2 (negative disables).
  task automatic run_frame(input string tag,
                           input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                           input logic pin,
                           input int la, input logic [11:0] lv,
                           input int la2, input logic [11:0] lv2,
                           input logic lh, input logic llz);
    logic [6:0] g [3];
    logic [2:0] one;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_pend;
    int         d;
    int         c;
    g[0] = g0;
    g[1] = g1;
    g[2] = g2;
    one  = 3'b001;
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk);
      load = 1'b0;
      d = i / int'(SCAN_DIV);
      c = i % int'(SCAN_DIV);
      exp_an   = (c < int'(BLANK_CYC)) ? 3'b111 : ~(one << d);
      exp_seg  = (c < int'(BLANK_CYC)) ? 7'h7F : g[d];
      exp_pend = (la >= 0 && i > la) ? 1'b1 : pin;
      check($sformatf("%s_fs[%0d]", tag, i), 32'(frame_start), 32'(i == 0));
      check($sformatf("%s_an[%0d]", tag, i), 32'(an), 32'(exp_an));
      check($sformatf("%s_seg[%0d]", tag, i), 32'(seg), 32'(exp_seg));
      check($sformatf("%s_pend[%0d]", tag, i), 32'(pending), 32'(exp_pend));
      if (i == la) begin
        load = 1'b1; value = lv; hex_en = lh; lz_en = llz;
      end
      if (i == la2) begin
        load = 1'b1; value = lv2; hex_en = lh; lz_en = llz;
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    value  = 12'h000;
    hex_en = 1'b0;
    lz_en  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'h7);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    rst_n = 1'b1;

    // First frame after release shows zeros.
    run_frame("first", 7'h40, 7'h40, 7'h40, 1'b0, -1, 12'h000, -1, 12'h000, 1'b0, 1'b0);
    // Load mid-frame: current frame keeps old data, pending rises.
    run_frame("defer_old", 7'h40, 7'h40, 7'h40, 1'b0, 10, 12'h395, -1, 12'h000, 1'b0, 1'b0);
    // Committed 395; queue hex AbF.
    run_frame("defer_new", 7'h12, 7'h10, 7'h30, 1'b0, 5, 12'hABF, -1, 12'h000, 1'b1, 1'b0);
    // Hex glyphs F, b, A; queue same value with hex off.
    run_frame("hex_on", 7'h0E, 7'h03, 7'h08, 1'b0, 5, 12'hABF, -1, 12'h000, 1'b0, 1'b0);
    // All blank; queue 007 with leading-zero suppression.
    run_frame("hex_off", 7'h7F, 7'h7F, 7'h7F, 1'b0, 5, 12'h007, -1, 12'h000, 1'b0, 1'b1);
    // Digit 0 shows 7, upper digits suppressed; queue 000.
    run_frame("lz_007", 7'h78, 7'h7F, 7'h7F, 1'b0, 5, 12'h000, -1, 12'h000, 1'b0, 1'b1);
    // Only digit 0 shows 0; load 421 on the boundary edge.
    run_frame("lz_000", 7'h40, 7'h7F, 7'h7F, 1'b0, 23, 12'h421, -1, 12'h000, 1'b0, 1'b0);
    // Bypassed 421 shows immediately, pending never set; back-to-back loads.
    run_frame("bypass", 7'h79, 7'h24, 7'h19, 1'b0, 3, 12'h111, 4, 12'h222, 1'b0, 1'b0);
    // Last load wins.
    run_frame("b2b", 7'h24, 7'h24, 7'h24, 1'b0, -1, 12'h000, -1, 12'h000, 1'b0, 1'b0);

    // Reset while digit 1 is driven with a pending value.
    @(negedge clk);
    check("pre_rst_fs", 32'(frame_start), 32'h1);
    load = 1'b1; value = 12'h999; hex_en = 1'b0; lz_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
    check("pre_rst_an", 32'(an), 32'h5);
    check("pre_rst_pend", 32'(pending), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_an", 32'(an), 32'h7);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_pend", 32'(pending), 32'h0);
    check("mid_rst_fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    run_frame("post_rst", 7'h40, 7'h40, 7'h40, 1'b0, -1, 12'h000, -1, 12'h000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
